// File: rtl/mem_req_queue.sv
// mem_req_queue: host request FIFO in front of the memory controller.
// Issues one request at a time on the mc_* pins, recognises completion from
// the controller's command output, and returns a response on a valid/ready
// channel. A watchdog converts a stalled request into an error response.
module mem_req_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_rnw,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_rnw,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       mc_cmd_n,
  output logic                       mc_rdnwr,
  output logic [ADDR_W-1:0]          mc_addr,
  output logic [DATA_W-1:0]          mc_data_in,
  output logic                       mc_data_in_vld,
  input  logic [2:0]                 mc_command,
  input  logic [DATA_W-1:0]          mc_data_out,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [OCC_W-1:0] DEPTH_C    = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0]       CMD_READ   = 3'b010;
  localparam logic [2:0]       CMD_WRITE  = 3'b011;

  typedef enum logic [1:0] {IDLE, ISSUE, RD_CAP, RSP} state_t;

  state_t               state_reg, state_next;
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [OCC_W-1:0]     occ_reg;
  logic [CNT_W-1:0]     to_cnt_reg;

  // Request storage: no reset needed, validity is tracked by the pointers.
  logic                 rnw_mem  [DEPTH];
  logic [ADDR_W-1:0]    addr_mem [DEPTH];
  logic [DATA_W-1:0]    data_mem [DEPTH];

  logic push, pop, enter_issue, wr_done, rd_done, timed_out, capture;
  logic head_rnw;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  assign req_ready = (occ_reg < DEPTH_C);
  assign push      = req_valid && req_ready;
  assign occupancy = occ_reg;
  assign busy      = (state_reg != IDLE) || (occ_reg != '0);

  // When leaving RSP with an empty FIFO and a push in the same cycle, the
  // new entry is not yet in storage, so take the head straight from the host.
  assign head_rnw   = (occ_reg == '0) ? req_rnw   : rnw_mem[rd_ptr_reg];
  assign head_addr  = (occ_reg == '0) ? req_addr  : addr_mem[rd_ptr_reg];
  assign head_wdata = (occ_reg == '0) ? req_wdata : data_mem[rd_ptr_reg];

  // Write accepted requests into the FIFO storage.
  always_ff @(posedge clk) begin
    if (push) begin
      rnw_mem[wr_ptr_reg]  <= req_rnw;
      addr_mem[wr_ptr_reg] <= req_addr;
      data_mem[wr_ptr_reg] <= req_wdata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + OCC_W'(1);
        2'b01:   occ_reg <= occ_reg - OCC_W'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state logic; completion takes priority over the watchdog.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (occ_reg != '0) state_next = ISSUE;
      ISSUE: begin
        if (wr_done)        state_next = RSP;
        else if (rd_done)   state_next = RD_CAP;
        else if (timed_out) state_next = RSP;
      end
      RD_CAP: state_next = RSP;
      RSP:    if (rsp_ready) state_next = ((occ_reg != '0) || push) ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: completion detection and datapath strobes.
  always_comb begin
    wr_done     = (state_reg == ISSUE) && !mc_rdnwr && (mc_command == CMD_WRITE);
    rd_done     = (state_reg == ISSUE) &&  mc_rdnwr && (mc_command == CMD_READ);
    timed_out   = (state_reg == ISSUE) && (to_cnt_reg == TO_LAST);
    pop         = wr_done || rd_done || timed_out;
    capture     = (state_reg == RD_CAP);
    enter_issue = (state_next == ISSUE) && (state_reg != ISSUE);
    rsp_valid   = (state_reg == RSP);
  end

  // Watchdog: counts cycles spent in ISSUE, restarting on each entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  to_cnt_reg <= '0;
    else if (state_reg != ISSUE) to_cnt_reg <= '0;
    else                         to_cnt_reg <= to_cnt_reg + CNT_W'(1);
  end

  // Controller pins: loaded from the head on ISSUE entry, held through ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_cmd_n       <= 1'b1;
      mc_rdnwr       <= 1'b0;
      mc_addr        <= '0;
      mc_data_in     <= '0;
      mc_data_in_vld <= 1'b0;
    end else if (enter_issue) begin
      mc_cmd_n       <= 1'b0;
      mc_rdnwr       <= head_rnw;
      mc_addr        <= head_addr;
      mc_data_in     <= head_wdata;
      mc_data_in_vld <= !head_rnw;
    end else if (state_next != ISSUE) begin
      mc_cmd_n       <= 1'b1;
      mc_data_in_vld <= 1'b0;
    end
  end

  // Response register: loaded on write/timeout completion or read capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rnw   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (wr_done) begin
      rsp_rnw   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (timed_out && !rd_done) begin
      rsp_rnw   <= mc_rdnwr;
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end else if (capture) begin
      rsp_rnw   <= 1'b1;
      rsp_rdata <= mc_data_out;
      rsp_err   <= 1'b0;
    end
  end

endmodule
